bin_seq_checker: RTL and testbench
==================================

BIN_SEQ_CHECKER -- requirements
Module: bin_seq_checker

Interface
REQ-001 Parameter WIDTH, default 3: bit width of the monitored count stream.
REQ-002 Parameter LOCK_LEN, default 4: number of consecutive correct increments required to declare lock (legal range 1..15).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 count_in  input  WIDTH  sample from the binary sequence generator under observation.
REQ-006 valid  input  1  count_in is sampled only in cycles where valid is 1.
REQ-007 locked  output  1  stream has followed the +1 sequence for at least LOCK_LEN consecutive samples.
REQ-008 err  output  1  one-cycle pulse: a sequence violation was detected.
REQ-009 wrap  output  1  one-cycle pulse: a legal wrap from all-ones to zero was observed.
REQ-010 err_cnt  output  8  total violations since reset, saturating.

Function
REQ-011 The block SHALL hold prev[WIDTH-1:0], a match counter run_cnt[3:0] and a 3-state FSM: IDLE, ACQUIRE, LOCKED.
REQ-012 The expected value SHALL be (prev + 1) mod 2^WIDTH; all-ones followed by zero is a correct increment.
REQ-013 Cycles with valid=0 SHALL change no state; prev, run_cnt, FSM and err_cnt hold; err and wrap are 0.
REQ-014 IDLE, valid=1: prev <= count_in, run_cnt <= 0, go to ACQUIRE; no check, no err.
REQ-015 ACQUIRE, valid=1, match: run_cnt increments; when it reaches LOCK_LEN, go to LOCKED.
REQ-016 ACQUIRE, valid=1, mismatch: run_cnt <= 0, stay in ACQUIRE, err pulses, err_cnt increments.
REQ-017 LOCKED, valid=1, match: stay in LOCKED; run_cnt holds at LOCK_LEN.
REQ-018 LOCKED, valid=1, mismatch: go to ACQUIRE, run_cnt <= 0, err pulses, err_cnt increments.
REQ-019 Every accepted sample (valid=1) in ACQUIRE or LOCKED SHALL update prev <= count_in, including on mismatch, so checking resynchronises to the new value.
REQ-020 A repeated value (count_in == prev) SHALL count as a mismatch.
REQ-021 wrap SHALL pulse for any matching sample where prev is all-ones and count_in is zero, in ACQUIRE or LOCKED.
REQ-022 All outputs SHALL be registered; err, wrap, locked and err_cnt reflect a sample on the rising edge that captures it (visible one cycle after the sample is presented).
REQ-023 locked SHALL equal (FSM == LOCKED).
REQ-024 err_cnt SHALL saturate at 255 and never wrap.
REQ-025 A generator restart (e.g. 5 then 0) SHALL be reported as a violation; no exemption for zero.

Reset
REQ-026 rst=1 at a rising edge SHALL set FSM=IDLE, prev=0, run_cnt=0, locked=0, err=0, wrap=0, err_cnt=0, regardless of valid.
REQ-027 rst SHALL take priority over valid and count_in in the same cycle; the first sample after rst deasserts is treated as in IDLE.

Structure
REQ-028 FSM state encoding and the err_cnt width constant (8) SHALL live in a shared package, seq_pkg.
REQ-029 The block SHALL be a single module; no sub-module is required.

Verification
REQ-030 Reset then valid=1 with count_in 0,1,2,3,4 -> locked rises after the sample 4 is captured; err never pulses; err_cnt=0.
REQ-031 Locked stream ...6,7,0,1 -> wrap pulses exactly once, on capture of 0; locked stays 1.
REQ-032 Locked stream 2,3,5,6 -> err pulses on capture of 5, locked falls same edge, err_cnt=1; relock after 6,7,0,1 (4 matches).
REQ-033 Stream 3,4,valid=0 for 5 cycles with count_in=7,then 5 -> no err; 5 treated as match to 4.
REQ-034 Locked at count 5, generator reset drives 0,1,2 -> one err on 0, err_cnt increments by 1, ACQUIRE resumes from 0.
REQ-035 Drive 300 mismatches (constant value 3) -> err_cnt saturates at 255; then assert rst mid-stream -> all outputs 0 on the next edge.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared definitions for the binary sequence checker: FSM encoding and counter widths.
// Pure constants; no logic, no latency.
package seq_pkg;
  localparam int ERR_CNT_W = 8;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ACQUIRE = 2'd1;
  localparam logic [1:0] ST_LOCKED  = 2'd2;
endpackage

// File: rtl/bin_seq_checker_if.sv
// Sample stream in (count_in/valid) and checker status out (locked/err/wrap/err_cnt).
// The sample side has no backpressure; a sample is consumed whenever valid is high.
interface bin_seq_checker_if #(
  parameter int WIDTH = 3
);
  import seq_pkg::*;

  logic [WIDTH-1:0]     count_in;
  logic                 valid;
  logic                 locked;
  logic                 err;
  logic                 wrap;
  logic [ERR_CNT_W-1:0] err_cnt;

  modport master (output count_in, valid, input locked, err, wrap, err_cnt);
  modport slave  (input count_in, valid, output locked, err, wrap, err_cnt);
endinterface

// File: rtl/bin_seq_checker.sv
// Checks that a sampled count stream follows +1 mod 2^WIDTH; reports lock, err/wrap pulses, saturating error count.
// All outputs registered, one cycle after the sample; never stalls the source (valid-only input).
module bin_seq_checker
  import seq_pkg::*;
#(
  parameter int WIDTH    = 3,
  parameter int LOCK_LEN = 4
) (
  input  logic             clk,
  input  logic             rst,
  bin_seq_checker_if.slave bus
);
  localparam logic [3:0]       LOCK_LEN_C = 4'(LOCK_LEN);
  localparam logic [WIDTH-1:0] ONE_C      = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [1:0]           state_q, state_d;
  logic [WIDTH-1:0]     prev_q, prev_d;
  logic [3:0]           run_cnt_q, run_cnt_d;
  logic                 locked_q, locked_d;
  logic                 err_q, err_d;
  logic                 wrap_q, wrap_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

  logic [WIDTH-1:0] expected;
  logic             match;

  assign expected = prev_q + ONE_C;
  assign match    = (bus.count_in == expected);

  always_comb begin
    state_d   = state_q;
    prev_d    = prev_q;
    run_cnt_d = run_cnt_q;
    err_cnt_d = err_cnt_q;
    err_d     = 1'b0;
    wrap_d    = 1'b0;
    if (bus.valid) begin
      prev_d = bus.count_in;
      if (state_q == ST_IDLE) begin
        run_cnt_d = 4'd0;
        state_d   = ST_ACQUIRE;
      end else if (match) begin
        wrap_d = &prev_q;
        if (state_q == ST_ACQUIRE) begin
          run_cnt_d = run_cnt_q + 4'd1;
          if (run_cnt_d == LOCK_LEN_C) state_d = ST_LOCKED;
        end
      end else begin
        // Mismatch from either checking state drops back to acquisition.
        run_cnt_d = 4'd0;
        state_d   = ST_ACQUIRE;
        err_d     = 1'b1;
        if (err_cnt_q != {ERR_CNT_W{1'b1}}) err_cnt_d = err_cnt_q + 1'b1;
      end
    end
    locked_d = (state_d == ST_LOCKED);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      prev_q    <= '0;
      run_cnt_q <= 4'd0;
      locked_q  <= 1'b0;
      err_q     <= 1'b0;
      wrap_q    <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      prev_q    <= prev_d;
      run_cnt_q <= run_cnt_d;
      locked_q  <= locked_d;
      err_q     <= err_d;
      wrap_q    <= wrap_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign bus.locked  = locked_q;
  assign bus.err     = err_q;
  assign bus.wrap    = wrap_q;
  assign bus.err_cnt = err_cnt_q;
endmodule

// File: tb/tb_bin_seq_checker.sv
// Directed plus randomized stimulus for bin_seq_checker, checked against a streak-counting reference model.
module tb_bin_seq_checker;
  localparam int W   = 3;
  localparam int L   = 4;
  localparam int MOD = 1 << W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bin_seq_checker_if #(.WIDTH(W)) bus ();

  bin_seq_checker #(.WIDTH(W), .LOCK_LEN(L)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: a stream is locked once it has L or more consecutive correct increments.
  bit m_started;
  int m_prev;
  int m_streak;
  int m_errs;
  bit m_err;
  bit m_wrap;

  task automatic model_reset();
    m_started = 0;
    m_prev    = 0;
    m_streak  = 0;
    m_errs    = 0;
    m_err     = 0;
    m_wrap    = 0;
  endtask

  task automatic model_sample(input bit v, input int c);
    m_err  = 0;
    m_wrap = 0;
    if (!v) return;
    if (!m_started) begin
      m_started = 1;
      m_streak  = 0;
    end else if (c == (m_prev + 1) % MOD) begin
      m_streak++;
      m_wrap = (m_prev == MOD - 1);
    end else begin
      m_streak = 0;
      m_err    = 1;
      if (m_errs < 255) m_errs++;
    end
    m_prev = c;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input bit r, input bit v, input int c);
    rst          = r;
    bus.valid    = v;
    bus.count_in = W'(c);
    @(posedge clk);
    if (r) model_reset();
    else model_sample(v, c);
    #1;
    check("locked",  {31'd0, bus.locked}, {31'd0, (m_started && m_streak >= L)});
    check("err",     {31'd0, bus.err},    {31'd0, m_err});
    check("wrap",    {31'd0, bus.wrap},   {31'd0, m_wrap});
    check("err_cnt", {24'd0, bus.err_cnt}, 32'(m_errs));
  endtask

  int c;

  initial begin
    model_reset();
    bus.valid    = 1'b0;
    bus.count_in = '0;

    step(1, 1, 5);
    step(1, 0, 0);
    check("rst_locked", {31'd0, bus.locked}, 32'd0);
    check("rst_errcnt", {24'd0, bus.err_cnt}, 32'd0);

    // Clean acquisition: lock after the fourth increment.
    step(0, 1, 0); step(0, 1, 1); step(0, 1, 2); step(0, 1, 3);
    check("not_locked_yet", {31'd0, bus.locked}, 32'd0);
    step(0, 1, 4);
    check("lock_at_4", {31'd0, bus.locked}, 32'd1);

    // Wrap through all-ones to zero while locked.
    step(0, 1, 5); step(0, 1, 6); step(0, 1, 7);
    step(0, 1, 0);
    check("wrap_pulse", {31'd0, bus.wrap}, 32'd1);
    step(0, 1, 1);
    check("wrap_once", {31'd0, bus.wrap}, 32'd0);

    // Skip 4: error, drop lock, then relock after four matches.
    step(0, 1, 2); step(0, 1, 3);
    step(0, 1, 5);
    check("skip_err",    {31'd0, bus.err},    32'd1);
    check("skip_unlock", {31'd0, bus.locked}, 32'd0);
    check("skip_errcnt", {24'd0, bus.err_cnt}, 32'd1);
    step(0, 1, 6); step(0, 1, 7); step(0, 1, 0); step(0, 1, 1);
    check("relock", {31'd0, bus.locked}, 32'd1);

    // Idle gaps with junk on count_in must be ignored.
    step(0, 1, 2); step(0, 1, 3); step(0, 1, 4);
    for (int i = 0; i < 5; i++) step(0, 0, 7);
    step(0, 1, 5);
    check("gap_no_err", {31'd0, bus.err}, 32'd0);
    check("gap_locked", {31'd0, bus.locked}, 32'd1);

    // Generator restart from 5 to 0 is a single violation.
    step(0, 1, 0);
    check("restart_err", {31'd0, bus.err}, 32'd1);
    step(0, 1, 1); step(0, 1, 2);
    check("restart_errcnt", {24'd0, bus.err_cnt}, 32'd2);

    // Repeated value counts as a mismatch.
    step(0, 1, 2);
    check("repeat_err", {31'd0, bus.err}, 32'd1);

    // Random mix of gaps, good increments and corrupt samples.
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 4) == 0) c = int'($urandom_range(0, MOD - 1));
      else c = (m_prev + 1) % MOD;
      step(0, ($urandom_range(0, 3) != 0), c);
    end

    // Saturation of the error counter, then reset mid-stream.
    for (int i = 0; i < 300; i++) step(0, 1, 3);
    check("sat_errcnt", {24'd0, bus.err_cnt}, 32'd255);
    step(1, 1, 4);
    check("rst_mid_locked", {31'd0, bus.locked}, 32'd0);
    check("rst_mid_err",    {31'd0, bus.err},    32'd0);
    check("rst_mid_errcnt", {24'd0, bus.err_cnt}, 32'd0);

    // First sample after reset is absorbed without checking.
    step(0, 1, 6);
    check("post_rst_no_err", {31'd0, bus.err}, 32'd0);
    step(0, 1, 7);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
